// File: rtl/dsdmnist_arith_prims_pkg.sv
// Shared widths for the MNIST dot-product arithmetic primitives.
package dsdmnist_arith_prims_pkg;
  localparam int MULADD_OPW   = 8;
  localparam int MULADD_PRODW = 16;
  localparam int MULADD_RESW  = 17;
  localparam int ADD_OPW      = 17;
  localparam int ACC_OPW      = 23;
  localparam int ACC_W        = 32;
endpackage

// File: rtl/dsdmnist_arith_prims_units.sv
// Pipelined signed primitives: 2-cycle multiply-add leaf, 1-cycle 3-input adder,
// 1-cycle accumulator that restarts from the current operands when i_EN is low.
module dsdmnist_4op_muladd
  import dsdmnist_arith_prims_pkg::*;
#(
  parameter string USEDSP = "no"
) (
  input  logic                     i_CLK,
  input  logic signed [7:0]        i_OPSET0 [0:1],
  input  logic signed [7:0]        i_OPSET1 [0:1],
  output logic signed [16:0]       o_RESULT
);
  logic signed [MULADD_PRODW-1:0] p0;
  logic signed [MULADD_PRODW-1:0] p1;

  // Only the placement hint differs between the two builds.
  generate
    if (USEDSP == "yes") begin : g_dsp
      (* use_dsp = "yes" *) logic signed [MULADD_PRODW-1:0] p0_reg;
      (* use_dsp = "yes" *) logic signed [MULADD_PRODW-1:0] p1_reg;
      always_ff @(posedge i_CLK) begin
        p0_reg <= 16'(i_OPSET0[0]) * 16'(i_OPSET1[0]);
        p1_reg <= 16'(i_OPSET0[1]) * 16'(i_OPSET1[1]);
      end
      assign p0 = p0_reg;
      assign p1 = p1_reg;
    end else begin : g_fabric
      (* use_dsp = "no" *) logic signed [MULADD_PRODW-1:0] p0_reg;
      (* use_dsp = "no" *) logic signed [MULADD_PRODW-1:0] p1_reg;
      always_ff @(posedge i_CLK) begin
        p0_reg <= 16'(i_OPSET0[0]) * 16'(i_OPSET1[0]);
        p1_reg <= 16'(i_OPSET0[1]) * 16'(i_OPSET1[1]);
      end
      assign p0 = p0_reg;
      assign p1 = p1_reg;
    end
  endgenerate

  // (-128)*(-128) twice gives +32768, which needs the 17th bit.
  always_ff @(posedge i_CLK) begin
    o_RESULT <= 17'(p0) + 17'(p1);
  end
endmodule

module dsdmnist_3op_add #(
  parameter int OPW = 17
) (
  input  logic                  i_CLK,
  input  logic signed [OPW-1:0] i_OP0,
  input  logic signed [OPW-1:0] i_OP1,
  input  logic signed [OPW-1:0] i_OP2,
  output logic signed [OPW+1:0] o_RESULT
);
  localparam int RW = OPW + 2;

  always_ff @(posedge i_CLK) begin
    o_RESULT <= RW'(i_OP0) + RW'(i_OP1) + RW'(i_OP2);
  end
endmodule

module dsdmnist_3op_acc #(
  parameter int OPW = 23
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_EN,
  input  logic signed [OPW-1:0] i_OP0,
  input  logic signed [OPW-1:0] i_OP1,
  output logic signed [31:0]    o_ACC
);
  localparam int ACCW = 32;

  logic signed [ACCW-1:0] sum;

  assign sum = ACCW'(i_OP0) + ACCW'(i_OP1);

  // Low i_EN reloads with this cycle's operands rather than clearing to zero.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_ACC <= '0;
    end else if (i_EN) begin
      o_ACC <= o_ACC + sum;
    end else begin
      o_ACC <= sum;
    end
  end
endmodule

// File: rtl/dsdmnist_arith_prims.sv
// Wrapper exposing every primitive, with both placement builds of the multiply-add leaf.
module dsdmnist_arith_prims
  import dsdmnist_arith_prims_pkg::*;
(
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic signed [MULADD_OPW-1:0]  muladd_a [0:1],
  input  logic signed [MULADD_OPW-1:0]  muladd_b [0:1],
  output logic signed [MULADD_RESW-1:0] muladd_dsp_result,
  output logic signed [MULADD_RESW-1:0] muladd_fab_result,
  input  logic signed [ADD_OPW-1:0]     add_op0,
  input  logic signed [ADD_OPW-1:0]     add_op1,
  input  logic signed [ADD_OPW-1:0]     add_op2,
  output logic signed [ADD_OPW+1:0]     add_result,
  input  logic                          acc_en,
  input  logic signed [ACC_OPW-1:0]     acc_op0,
  input  logic signed [ACC_OPW-1:0]     acc_op1,
  output logic signed [ACC_W-1:0]       acc_result
);
  dsdmnist_4op_muladd #(.USEDSP("yes")) u_muladd_dsp (
    .i_CLK    (i_CLK),
    .i_OPSET0 (muladd_a),
    .i_OPSET1 (muladd_b),
    .o_RESULT (muladd_dsp_result)
  );

  dsdmnist_4op_muladd #(.USEDSP("no")) u_muladd_fab (
    .i_CLK    (i_CLK),
    .i_OPSET0 (muladd_a),
    .i_OPSET1 (muladd_b),
    .o_RESULT (muladd_fab_result)
  );

  dsdmnist_3op_add #(.OPW(ADD_OPW)) u_add (
    .i_CLK    (i_CLK),
    .i_OP0    (add_op0),
    .i_OP1    (add_op1),
    .i_OP2    (add_op2),
    .o_RESULT (add_result)
  );

  dsdmnist_3op_acc #(.OPW(ACC_OPW)) u_acc (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_EN  (acc_en),
    .i_OP0 (acc_op0),
    .i_OP1 (acc_op1),
    .o_ACC (acc_result)
  );
endmodule

// File: tb/tb_dsdmnist_arith_prims.sv
// Scoreboard bench: stimulus queues expected results with their due cycle, a monitor pops them.
module tb_dsdmnist_arith_prims;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [7:0]  muladd_a [0:1];
  logic signed [7:0]  muladd_b [0:1];
  logic signed [16:0] muladd_dsp_result;
  logic signed [16:0] muladd_fab_result;
  logic signed [16:0] add_op0, add_op1, add_op2;
  logic signed [18:0] add_result;
  logic               acc_en;
  logic signed [22:0] acc_op0, acc_op1;
  logic signed [31:0] acc_result;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t mul_q[$];
  exp_t add_q[$];
  exp_t acc_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int acc_model = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsdmnist_arith_prims dut (
    .i_CLK             (clk),
    .i_RST             (rst),
    .muladd_a          (muladd_a),
    .muladd_b          (muladd_b),
    .muladd_dsp_result (muladd_dsp_result),
    .muladd_fab_result (muladd_fab_result),
    .add_op0           (add_op0),
    .add_op1           (add_op1),
    .add_op2           (add_op2),
    .add_result        (add_result),
    .acc_en            (acc_en),
    .acc_op0           (acc_op0),
    .acc_op1           (acc_op1),
    .acc_result        (acc_result)
  );

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) begin
      n_pass++;
      if (verbose) $display("cyc %0d %s got %0d want %0d ok", cyc, name, got, want);
    end else begin
      $display("FAIL cyc %0d %s got %0d want %0d", cyc, name, got, want);
    end
  endtask

  // One clock of stimulus for all primitives; expected values come from plain integer arithmetic.
  task automatic drive(input int a0, input int a1, input int b0, input int b1,
                       input int x0, input int x1, input int x2,
                       input bit r, input bit en, input int c0, input int c1);
    muladd_a[0] = 8'(a0);
    muladd_a[1] = 8'(a1);
    muladd_b[0] = 8'(b0);
    muladd_b[1] = 8'(b1);
    add_op0 = 17'(x0);
    add_op1 = 17'(x1);
    add_op2 = 17'(x2);
    rst = r;
    acc_en = en;
    acc_op0 = 23'(c0);
    acc_op1 = 23'(c1);
    mul_q.push_back('{due: cyc + 2, val: a0 * b0 + a1 * b1});
    add_q.push_back('{due: cyc + 1, val: x0 + x1 + x2});
    if (r) acc_model = 0;
    else if (en) acc_model = acc_model + c0 + c1;
    else acc_model = c0 + c1;
    acc_q.push_back('{due: cyc + 1, val: acc_model});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (mul_q.size() > 0 && mul_q[0].due == cyc) begin
      e = mul_q.pop_front();
      check("muladd_dsp", int'(muladd_dsp_result), e.val);
      check("muladd_fab", int'(muladd_fab_result), e.val);
    end
    while (add_q.size() > 0 && add_q[0].due == cyc) begin
      e = add_q.pop_front();
      check("add3", int'(add_result), e.val);
    end
    while (acc_q.size() > 0 && acc_q[0].due == cyc) begin
      e = acc_q.pop_front();
      check("acc", int'(acc_result), e.val);
    end
  end

  function automatic int rnd8();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) return -128;
    if (k == 1) return 127;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst = 1'b1;
    acc_en = 1'b0;
    muladd_a[0] = '0; muladd_a[1] = '0;
    muladd_b[0] = '0; muladd_b[1] = '0;
    add_op0 = '0; add_op1 = '0; add_op2 = '0;
    acc_op0 = '0; acc_op1 = '0;
    @(posedge clk);
    #1;
    // Directed: reset priority, restart, accumulate, range extremes
    drive(3, -4, 5, 6, 65535, 65535, 65535, 1'b1, 1'b1, 9, 9);
    drive(-128, -128, -128, -128, -65536, -65536, -65536, 1'b0, 1'b0, 10, 5);
    drive(127, -128, -128, 127, 1, -2, 3, 1'b0, 1'b1, -20, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 100, 1);
    drive(1, 1, 1, 1, -1, 0, 0, 1'b0, 1'b0, 1, 0);
    drive(-1, 2, 3, -4, 0, 0, 0, 1'b0, 1'b1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 2, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 7, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, -4194304, 4194303);
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(rnd8(), rnd8(), rnd8(), rnd8(),
            int'($urandom_range(0, 131071)) - 65536,
            int'($urandom_range(0, 131071)) - 65536,
            int'($urandom_range(0, 131071)) - 65536,
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 8388607)) - 4194304,
            int'($urandom_range(0, 8388607)) - 4194304);
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", mul_q.size() + add_q.size() + acc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
